// File: rtl/life_engine_param.sv
// Parametrised Game-of-Life core: holds the board, computes generations with
// selectable birth/survive masks and edge mode, and serves a registered read port.

module life_engine_param #(
  parameter int          LOG_W           = 6,
  parameter int          LOG_H           = 5,
  parameter int          UPDATE_INTERVAL = 2400000,
  parameter logic [15:0] LFSR_SEED       = 16'h0001
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   step,
  input  logic                   randomize,
  input  logic                   clear,
  input  logic                   wrap_en,
  input  logic [8:0]             birth_mask,
  input  logic [8:0]             survive_mask,
  input  logic                   vsync,
  input  logic [LOG_W+LOG_H-1:0] rd_addr,
  output logic                   rd_data,
  output logic                   busy,
  output logic [15:0]            gen_count,
  output logic [LOG_W+LOG_H:0]   pop_count
);

  localparam int AW = LOG_W + LOG_H;
  localparam int N  = 1 << AW;
  localparam int TW = $clog2(UPDATE_INTERVAL + 1);
  localparam logic [TW-1:0] INTERVAL  = TW'(UPDATE_INTERVAL);
  localparam logic [AW-1:0] LAST_CELL = '1;

  typedef enum logic [2:0] {IDLE, INIT, CLEAR, UPDATE, COPY} state_t;

  state_t          state, state_d;
  logic [TW-1:0]   timer;
  logic [AW-1:0]   idx;
  logic [3:0]      phase;
  logic [3:0]      ncount;
  logic            step_pending;
  logic            fire;
  logic [15:0]     lfsr;
  logic            lfsr_fb;
  logic [AW:0]     acc;
  logic [8:0]      birth_q;
  logic [8:0]      survive_q;
  logic            wrap_q;
  logic [N-1:0]    cur;
  logic [N-1:0]    nxt;
  logic [LOG_W-1:0] x, nx;
  logic [LOG_H-1:0] y, ny;
  logic            dxm, dxp, dym, dyp;
  logic            off_board;
  logic            nbr_bit;
  logic            new_cell;
  logic            last_cell;

  assign x         = idx[LOG_W-1:0];
  assign y         = idx[AW-1:LOG_W];
  assign last_cell = (idx == LAST_CELL);
  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign busy      = (state != IDLE);

  // Next-state logic; clear outranks any trigger arriving in the same cycle.
  always_comb begin
    state_d = state;
    fire    = 1'b0;
    case (state)
      IDLE: begin
        if (run) fire = (timer >= INTERVAL) && vsync;
        else     fire = step_pending && vsync;
        if (clear)     state_d = CLEAR;
        else if (fire) state_d = randomize ? INIT : UPDATE;
      end
      INIT:    if (last_cell) state_d = IDLE;
      CLEAR:   if (last_cell) state_d = IDLE;
      UPDATE:  if (last_cell && phase == 4'd8) state_d = COPY;
      COPY:    if (last_cell) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_d;
  end

  // Neighbour offset for the current phase, visited in a fixed order.
  always_comb begin
    {dxm, dxp, dym, dyp} = 4'b0000;
    case (phase)
      4'd0:    {dxm, dxp, dym, dyp} = 4'b1001;
      4'd1:    {dxm, dxp, dym, dyp} = 4'b0001;
      4'd2:    {dxm, dxp, dym, dyp} = 4'b0101;
      4'd3:    {dxm, dxp, dym, dyp} = 4'b1000;
      4'd4:    {dxm, dxp, dym, dyp} = 4'b0100;
      4'd5:    {dxm, dxp, dym, dyp} = 4'b1010;
      4'd6:    {dxm, dxp, dym, dyp} = 4'b0010;
      4'd7:    {dxm, dxp, dym, dyp} = 4'b0110;
      default: {dxm, dxp, dym, dyp} = 4'b0000;
    endcase
  end

  always_comb begin
    nx = x;
    ny = y;
    if (dxm) nx = x - LOG_W'(1);
    if (dxp) nx = x + LOG_W'(1);
    if (dym) ny = y - LOG_H'(1);
    if (dyp) ny = y + LOG_H'(1);
    off_board = (dxm && x == '0) || (dxp && x == '1) ||
                (dym && y == '0) || (dyp && y == '1);
    nbr_bit   = cur[{ny, nx}] && (wrap_q || !off_board);
    new_cell  = cur[idx] ? survive_q[ncount] : birth_q[ncount];
  end

  // Sequencing counters, timer, LFSR, rule shadows and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer        <= '0;
      idx          <= '0;
      phase        <= '0;
      ncount       <= '0;
      step_pending <= 1'b0;
      lfsr         <= LFSR_SEED;
      acc          <= '0;
      gen_count    <= '0;
      pop_count    <= '0;
      birth_q      <= '0;
      survive_q    <= '0;
      wrap_q       <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      case (state)
        IDLE: begin
          idx    <= '0;
          phase  <= '0;
          ncount <= '0;
          acc    <= '0;
          if (run && timer < INTERVAL) timer <= timer + TW'(1);
          if (run && fire && !clear)   timer <= '0;
          if (clear)                           step_pending <= 1'b0;
          else if (!run && step_pending && vsync) step_pending <= 1'b0;
          else if (!run && step)               step_pending <= 1'b1;
          if (state_d == UPDATE) begin
            birth_q   <= birth_mask;
            survive_q <= survive_mask;
            wrap_q    <= wrap_en;
          end
        end
        INIT: begin
          idx <= idx + AW'(1);
          acc <= acc + (AW+1)'(lfsr[0]);
          if (last_cell) begin
            pop_count <= acc + (AW+1)'(lfsr[0]);
            gen_count <= '0;
          end
        end
        CLEAR: begin
          idx       <= idx + AW'(1);
          pop_count <= '0;
          gen_count <= '0;
        end
        UPDATE: begin
          if (phase == 4'd8) begin
            phase  <= '0;
            ncount <= '0;
            idx    <= idx + AW'(1);
            acc    <= acc + (AW+1)'(new_cell);
          end else begin
            phase  <= phase + 4'd1;
            ncount <= ncount + 4'(nbr_bit);
          end
        end
        COPY: begin
          idx <= idx + AW'(1);
          if (last_cell) begin
            gen_count <= gen_count + 16'd1;
            pop_count <= acc;
          end
        end
        default: idx <= '0;
      endcase
    end
  end

  // Board storage carries no reset: INIT rewrites every cell after reset.
  always @(posedge clk) begin
    case (state)
      INIT:    cur[idx] <= lfsr[0];
      CLEAR:   cur[idx] <= 1'b0;
      UPDATE:  if (phase == 4'd8) nxt[idx] <= new_cell;
      COPY:    cur[idx] <= nxt[idx];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 1'b0;
    else        rd_data <= cur[rd_addr];
  end

endmodule

// File: tb/tb_life_engine_param.sv
// Directed bench for life_engine_param on an 8x8 board: reset fill, clear,
// oscillators, gliders in both edge modes, HighLife births and start timing.

module tb_life_engine_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, step, rnd, clear, wrap_en, vsync;
  logic [8:0]  birth, survive;
  logic [5:0]  rd_addr;
  logic        rd_data, busy;
  logic [15:0] gen_count;
  logic [6:0]  pop_count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  life_engine_param #(
    .LOG_W(3), .LOG_H(3), .UPDATE_INTERVAL(10), .LFSR_SEED(16'h0001)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .randomize(rnd),
    .clear(clear), .wrap_en(wrap_en), .birth_mask(birth), .survive_mask(survive),
    .vsync(vsync), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .gen_count(gen_count), .pop_count(pop_count)
  );

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  // Board expected after INIT from the seed: cell i holds LFSR bit 0 after i shifts.
  function automatic logic [63:0] lfsr_board();
    logic [15:0] l = 16'h0001;
    logic [63:0] b;
    for (int i = 0; i < 64; i++) begin
      b[i] = l[0];
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    return b;
  endfunction

  task automatic wait_busy(input logic level, input int limit, input string name);
    int n = 0;
    while (busy !== level && n < limit) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (busy !== level) begin
      tests_failed++;
      $display("[TB] FAIL %s timeout: busy=%b required %b", name, busy, level);
    end
  endtask

  task automatic read_board(output logic [63:0] b);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rd_addr = 6'(i);
      @(negedge clk);
      b[i] = rd_data;
    end
  endtask

  task automatic do_step(input string name);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_busy(1'b1, 10, {name, "_start"});
    wait_busy(1'b0, 2000, {name, "_done"});
  endtask

  task automatic clear_board();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_busy(1'b0, 200, "clear_done");
  endtask

  task automatic seed(input logic [63:0] p);
    @(negedge clk);
    dut.cur = p;
  endtask

  task automatic test_reset();
    logic [63:0] b, exp;
    rst_n = 1'b1; run = 0; step = 0; rnd = 0; clear = 0; wrap_en = 1; vsync = 1;
    birth = 9'h008; survive = 9'h00C; rd_addr = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (rd_data !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rd_data: got %b required 0", rd_data); end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b required 1", busy); end
    tests_run++;
    if (pop_count !== 7'd0 || gen_count !== 16'd0) begin
      tests_failed++; $display("[TB] FAIL reset_counts: got pop=%0d gen=%0d required 0 0", pop_count, gen_count);
    end
    rst_n = 1'b1;
    wait_busy(1'b0, 200, "reset_init_done");
    exp = lfsr_board();
    read_board(b);
    tests_run++;
    if (b !== exp) begin tests_failed++; $display("[TB] FAIL reset_board: got %h required %h", b, exp); end
    tests_run++;
    if (pop_count !== 7'($countones(exp))) begin
      tests_failed++; $display("[TB] FAIL reset_pop: got %0d required %0d", pop_count, $countones(exp));
    end
  endtask

  task automatic test_clear();
    logic [63:0] b;
    clear_board();
    read_board(b);
    tests_run++;
    if (b !== 64'd0) begin tests_failed++; $display("[TB] FAIL clear_board: got %h required 0", b); end
    tests_run++;
    if (pop_count !== 7'd0 || gen_count !== 16'd0) begin
      tests_failed++; $display("[TB] FAIL clear_counts: got pop=%0d gen=%0d required 0 0", pop_count, gen_count);
    end
  endtask

  task automatic test_blinker();
    logic [63:0] b, row, col;
    row = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
    col = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
    wrap_en = 1; birth = 9'h008; survive = 9'h00C;
    clear_board();
    seed(row);
    do_step("blinker1");
    read_board(b);
    tests_run++;
    if (b !== col) begin tests_failed++; $display("[TB] FAIL blinker_vertical: got %h required %h", b, col); end
    tests_run++;
    if (pop_count !== 7'd3 || gen_count !== 16'd1) begin
      tests_failed++; $display("[TB] FAIL blinker_counts1: got pop=%0d gen=%0d required 3 1", pop_count, gen_count);
    end
    do_step("blinker2");
    read_board(b);
    tests_run++;
    if (b !== row) begin tests_failed++; $display("[TB] FAIL blinker_horizontal: got %h required %h", b, row); end
    tests_run++;
    if (pop_count !== 7'd3 || gen_count !== 16'd2) begin
      tests_failed++; $display("[TB] FAIL blinker_counts2: got pop=%0d gen=%0d required 3 2", pop_count, gen_count);
    end
  endtask

  task automatic test_glider_wrap(input logic [63:0] g);
    logic [63:0] b;
    wrap_en = 1; birth = 9'h008; survive = 9'h00C;
    clear_board();
    seed(g);
    for (int s = 1; s <= 32; s++) begin
      do_step("glider_wrap");
      tests_run++;
      if (pop_count !== 7'd5) begin
        tests_failed++; $display("[TB] FAIL glider_wrap_pop step %0d: got %0d required 5", s, pop_count);
      end
    end
    read_board(b);
    tests_run++;
    if (b !== g) begin tests_failed++; $display("[TB] FAIL glider_wrap_return: got %h required %h", b, g); end
    tests_run++;
    if (gen_count !== 16'd32) begin tests_failed++; $display("[TB] FAIL glider_wrap_gen: got %0d required 32", gen_count); end
  endtask

  task automatic test_glider_dead_edge(input logic [63:0] g);
    logic [63:0] b, blk;
    logic [6:0]  pops [3] = '{7'd4, 7'd3, 7'd4};
    blk = (64'd1 << 54) | (64'd1 << 55) | (64'd1 << 62) | (64'd1 << 63);
    wrap_en = 0; birth = 9'h008; survive = 9'h00C;
    clear_board();
    seed(g);
    for (int s = 0; s < 3; s++) begin
      do_step("glider_edge");
      tests_run++;
      if (pop_count !== pops[s]) begin
        tests_failed++; $display("[TB] FAIL glider_edge_pop step %0d: got %0d required %0d", s + 1, pop_count, pops[s]);
      end
    end
    read_board(b);
    tests_run++;
    if (b !== blk) begin tests_failed++; $display("[TB] FAIL glider_edge_block: got %h required %h", b, blk); end
    for (int s = 0; s < 3; s++) begin
      do_step("block_hold");
      tests_run++;
      if (pop_count !== 7'd4) begin
        tests_failed++; $display("[TB] FAIL block_hold_pop step %0d: got %0d required 4", s + 1, pop_count);
      end
    end
    read_board(b);
    tests_run++;
    if (b !== blk || gen_count !== 16'd6) begin
      tests_failed++; $display("[TB] FAIL block_stable: got %h gen=%0d required %h gen=6", b, gen_count, blk);
    end
  endtask

  task automatic test_highlife();
    logic [63:0] b, p, hl, cw;
    p  = (64'd1 << 18) | (64'd1 << 19) | (64'd1 << 20) | (64'd1 << 34) | (64'd1 << 35) | (64'd1 << 36);
    cw = (64'd1 << 11) | (64'd1 << 19) | (64'd1 << 35) | (64'd1 << 43);
    hl = cw | (64'd1 << 27);
    wrap_en = 1; birth = 9'h048; survive = 9'h00C;
    clear_board();
    seed(p);
    do_step("highlife");
    read_board(b);
    tests_run++;
    if (b[27] !== 1'b1) begin tests_failed++; $display("[TB] FAIL highlife_birth6: got %b required 1", b[27]); end
    tests_run++;
    if (b !== hl || pop_count !== 7'd5) begin
      tests_failed++; $display("[TB] FAIL highlife_board: got %h pop=%0d required %h pop=5", b, pop_count, hl);
    end
    birth = 9'h008;
    clear_board();
    seed(p);
    do_step("conway6");
    read_board(b);
    tests_run++;
    if (b[27] !== 1'b0) begin tests_failed++; $display("[TB] FAIL conway_no_birth6: got %b required 0", b[27]); end
    tests_run++;
    if (b !== cw || pop_count !== 7'd4) begin
      tests_failed++; $display("[TB] FAIL conway_board: got %h pop=%0d required %h pop=4", b, pop_count, cw);
    end
  endtask

  task automatic test_timing();
    logic [15:0] gen_before;
    int          high_seen = 0;
    int          cnt = 0;
    gen_before = gen_count;
    @(negedge clk);
    vsync = 1'b0;
    run   = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) high_seen++;
    end
    tests_run++;
    if (high_seen !== 0) begin tests_failed++; $display("[TB] FAIL timing_no_vsync: got %0d busy cycles required 0", high_seen); end
    vsync = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL timing_start: busy got %b required 1", busy); end
    run = 1'b0;
    while (busy === 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    tests_run++;
    if (cnt !== 640) begin tests_failed++; $display("[TB] FAIL timing_busy_len: got %0d required 640", cnt); end
    tests_run++;
    if (gen_count !== gen_before + 16'd1) begin
      tests_failed++; $display("[TB] FAIL timing_gen: got %0d required %0d", gen_count, gen_before + 16'd1);
    end
  endtask

  task automatic test_reset_mid_update();
    logic [63:0] b, exp;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_busy(1'b1, 10, "mid_update_start");
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || gen_count !== 16'd0) begin
      tests_failed++; $display("[TB] FAIL mid_reset_state: got busy=%b gen=%0d required 1 0", busy, gen_count);
    end
    rst_n = 1'b1;
    wait_busy(1'b0, 200, "mid_reset_init_done");
    exp = lfsr_board();
    read_board(b);
    tests_run++;
    if (b !== exp) begin tests_failed++; $display("[TB] FAIL mid_reset_board: got %h required %h", b, exp); end
    tests_run++;
    if (gen_count !== 16'd0 || pop_count !== 7'($countones(exp))) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_counts: got gen=%0d pop=%0d required 0 %0d", gen_count, pop_count, $countones(exp));
    end
  endtask

  initial begin
    logic [63:0] glider;
    glider = (64'd1 << 46) | (64'd1 << 55) | (64'd1 << 61) | (64'd1 << 62) | (64'd1 << 63);
    test_reset();
    test_clear();
    test_blinker();
    test_glider_wrap(glider);
    test_glider_dead_edge(glider);
    test_highlife();
    test_timing();
    test_reset_mid_update();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
